// File: rtl/t03_sprite_loader.sv
`default_nettype none
// ============================================================================
// Module      : t03_sprite_loader
// Description : Loads a 15x20 RGB332 sprite from a valid/ready byte stream
//               into a packed 2400-bit register for the player display
//               blocks. When T03_SPRITE_DBUF_EN is defined, bytes are
//               collected in a shadow buffer and copied to the output during
//               vblank. Without it, bytes are written straight to the output.
// Revision    : 1.0 - initial release
// ============================================================================
module t03_sprite_loader #(
    parameter int NUM_PIXELS = 300,
    parameter int PIX_W      = 8
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        start,
    input  logic [PIX_W-1:0]            pix_data,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic                        vblank,
    output logic [NUM_PIXELS*PIX_W-1:0] player,
    output logic                        busy,
    output logic                        done
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_LOAD      = 2'd1;
    localparam logic [1:0] c_SWAP_WAIT = 2'd2;
    localparam logic [8:0] c_LAST      = 9'(NUM_PIXELS - 1);

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [8:0]                  r_cnt;
    logic                        r_done;
    logic                        w_done_set;
    logic                        w_beat;
    logic                        w_last;
    logic [NUM_PIXELS*PIX_W-1:0] r_player;

    // A start pulse blocks acceptance so a beat never lands on the old count.
    assign pix_ready = (r_state == c_LOAD) && !start;
    assign w_beat    = pix_valid && pix_ready;
    assign w_last    = w_beat && (r_cnt == c_LAST);
    assign busy      = (r_state == c_LOAD) || (r_state == c_SWAP_WAIT);
    assign done      = r_done;
    assign player    = r_player;

`ifdef T03_SPRITE_DBUF_EN
    logic                        w_swap;
    logic [NUM_PIXELS*PIX_W-1:0] r_shadow;

    // A restart in SWAP_WAIT wins over a coincident vblank: no swap.
    assign w_swap     = (r_state == c_SWAP_WAIT) && vblank && !start;
    assign w_done_set = w_swap;

    // Next state: start always (re)enters LOAD; the last beat waits for vblank.
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = c_LOAD;
        end else begin
            case (r_state)
                c_IDLE:      w_state_nxt = c_IDLE;
                c_LOAD:      if (w_last) w_state_nxt = c_SWAP_WAIT;
                c_SWAP_WAIT: if (vblank) w_state_nxt = c_IDLE;
                default:     w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Accepted beats fill the hidden buffer; pixel 0 lands in the top byte.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_shadow <= '0;
        end else begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (w_beat && (r_cnt == 9'(i))) begin
                    r_shadow[(NUM_PIXELS-1-i)*PIX_W +: PIX_W] <= pix_data;
                end
            end
        end
    end

    // The visible sprite only changes as a whole, at the vblank swap.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_player <= '0;
        end else if (w_swap) begin
            r_player <= r_shadow;
        end
    end
`else
    logic w_vblank_unused;

    // Without a shadow buffer the display timing is irrelevant.
    assign w_vblank_unused = vblank;
    assign w_done_set      = w_last;

    // Next state: start always (re)enters LOAD; the last beat returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = c_LOAD;
        end else begin
            case (r_state)
                c_IDLE:  w_state_nxt = c_IDLE;
                c_LOAD:  if (w_last) w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Accepted beats go straight to the visible sprite; pixel 0 is the top byte.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_player <= '0;
        end else begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (w_beat && (r_cnt == 9'(i))) begin
                    r_player[(NUM_PIXELS-1-i)*PIX_W +: PIX_W] <= pix_data;
                end
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pixel counter: cleared by start, advanced per accepted beat, wraps after the last.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + 9'd1;
        end
    end

    // Registered one-cycle pulse, high while the new sprite is first visible.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

endmodule
`default_nettype wire
